// File: rtl/led_frame_scheduler.sv
// led_frame_scheduler
//
// Owns the serial LED shift-register chain (LEDCLK/LEDDT). Two pattern
// producers request frames through valid/ready handshakes. When both are
// waiting, a round-robin pointer picks the winner. The accepted WIDTH-bit
// pattern is shifted out MSB first. Each bit gets a DIV-cycle low phase and
// a DIV-cycle high phase. An idle gap of GAP cycles follows the last bit,
// and then the next request may be granted.
//
// Ports:
//   clock          system clock (200 MHz)
//   reset          synchronous, active-high reset
//   io_reqK_valid  requester K offers a pattern (K = 0, 1)
//   io_reqK_data   requester K pattern, bit WIDTH-1 is shifted first
//   io_reqK_ready  requester K pattern accepted this cycle (combinational)
//   io_LEDCLK      registered serial clock, chain samples on rising edge
//   io_LEDDT       registered serial data
//   io_busy        a frame is in progress (state other than IDLE)
//   io_done        one-cycle pulse on the final gap cycle
//   io_last_src    requester whose frame was most recently accepted
module led_frame_scheduler #(
  parameter int WIDTH = 16,
  parameter int DIV   = 8,
  parameter int GAP   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_req0_valid,
  input  logic [WIDTH-1:0] io_req0_data,
  output logic             io_req0_ready,
  input  logic             io_req1_valid,
  input  logic [WIDTH-1:0] io_req1_data,
  output logic             io_req1_ready,
  output logic             io_LEDCLK,
  output logic             io_LEDDT,
  output logic             io_busy,
  output logic             io_done,
  output logic             io_last_src
);

  // One shared phase counter times both the DIV half periods and the gap,
  // so it is sized for whichever of the two is longer.
  localparam int CNT_MAX = (DIV > GAP) ? DIV : GAP;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BW      = $clog2(WIDTH);

  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
  localparam logic [BW-1:0] BIT_TOP  = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_GAP
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CW-1:0]    r_phaseCnt;
  logic [BW-1:0]    r_bitCnt;
  // The MSB of an accepted pattern goes straight to r_ledDt. Only the
  // remaining WIDTH-1 bits still waiting to be shifted out are kept here.
  logic [WIDTH-2:0] r_rest;
  logic             r_rrPtr;
  logic             r_lastSrc;
  logic             r_ledClk;
  logic             r_ledDt;

  logic             w_grantValid;
  logic             w_grantSrc;
  logic             w_ready0;
  logic             w_ready1;
  logic             w_xfer;
  logic [WIDTH-1:0] w_selData;
  logic             w_divLast;
  logic             w_gapLast;

  // Arbitration, handshake and next-state decode. A lone requester wins
  // regardless of the pointer; the pointer only breaks ties.
  always_comb begin
    w_grantValid = 1'b0;
    w_grantSrc   = 1'b0;
    w_nextState  = r_state;

    if (io_req0_valid && io_req1_valid) begin
      w_grantValid = 1'b1;
      w_grantSrc   = r_rrPtr;
    end else if (io_req0_valid) begin
      w_grantValid = 1'b1;
      w_grantSrc   = 1'b0;
    end else if (io_req1_valid) begin
      w_grantValid = 1'b1;
      w_grantSrc   = 1'b1;
    end

    w_ready0  = (r_state == S_IDLE) && !reset && w_grantValid && (w_grantSrc == 1'b0);
    w_ready1  = (r_state == S_IDLE) && !reset && w_grantValid && (w_grantSrc == 1'b1);
    w_xfer    = (w_ready0 && io_req0_valid) || (w_ready1 && io_req1_valid);
    w_selData = w_grantSrc ? io_req1_data : io_req0_data;
    w_divLast = (r_phaseCnt == DIV_LAST);
    w_gapLast = (r_phaseCnt == GAP_LAST);

    case (r_state)
      S_IDLE: begin
        if (w_xfer) w_nextState = S_SHIFT_LO;
      end
      S_SHIFT_LO: begin
        if (w_divLast) w_nextState = S_SHIFT_HI;
      end
      S_SHIFT_HI: begin
        if (w_divLast) w_nextState = (r_bitCnt == '0) ? S_GAP : S_SHIFT_LO;
      end
      S_GAP: begin
        if (w_gapLast) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // State register plus the frame datapath. LEDCLK/LEDDT are loaded on the
  // edge that enters each phase. As a result the first bit appears in the
  // cycle right after the transfer, and data only moves when the clock falls.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_phaseCnt <= '0;
      r_bitCnt   <= '0;
      r_rest     <= '0;
      r_rrPtr    <= 1'b0;
      r_lastSrc  <= 1'b0;
      r_ledClk   <= 1'b0;
      r_ledDt    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_rest     <= w_selData[WIDTH-2:0];
            r_ledDt    <= w_selData[WIDTH-1];
            r_ledClk   <= 1'b0;
            r_lastSrc  <= w_grantSrc;
            r_rrPtr    <= ~w_grantSrc;
            r_bitCnt   <= BIT_TOP;
            r_phaseCnt <= '0;
          end
        end
        S_SHIFT_LO: begin
          if (w_divLast) begin
            r_phaseCnt <= '0;
            r_ledClk   <= 1'b1;
          end else begin
            r_phaseCnt <= r_phaseCnt + 1'b1;
          end
        end
        S_SHIFT_HI: begin
          if (w_divLast) begin
            r_phaseCnt <= '0;
            r_ledClk   <= 1'b0;
            if (r_bitCnt != '0) begin
              r_ledDt  <= r_rest[WIDTH-2];
              r_rest   <= r_rest << 1;
              r_bitCnt <= r_bitCnt - 1'b1;
            end else begin
              r_ledDt  <= 1'b0;
            end
          end else begin
            r_phaseCnt <= r_phaseCnt + 1'b1;
          end
        end
        S_GAP: begin
          if (w_gapLast) r_phaseCnt <= '0;
          else           r_phaseCnt <= r_phaseCnt + 1'b1;
        end
        default: r_phaseCnt <= '0;
      endcase
    end
  end

  assign io_req0_ready = w_ready0;
  assign io_req1_ready = w_ready1;
  assign io_LEDCLK     = r_ledClk;
  assign io_LEDDT      = r_ledDt;
  assign io_busy       = (r_state != S_IDLE);
  // Gated by reset so that an aborted frame never reports completion.
  assign io_done       = (r_state == S_GAP) && w_gapLast && !reset;
  assign io_last_src   = r_lastSrc;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// tb_led_frame_scheduler
//
// Directed bench for led_frame_scheduler. The main instance uses DIV=2,
// WIDTH=16, GAP=4, which gives a 68-cycle frame. A second instance uses
// DIV=1, GAP=1, which gives a 33-cycle frame. A posedge monitor logs
// transfers, done pulses and the data bit seen at each LEDCLK rising edge.
// Each test task compares those logs with hand-computed values.
module tb_led_frame_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [15:0] d0 = '0, d1 = '0;
  logic        r0, r1, ledClk, ledDt, busy, done, lastSrc;
  logic        bv0 = 1'b0, bv1 = 1'b0;
  logic [15:0] bd0 = '0, bd1 = '0;
  logic        br0, br1, bLedClk, bLedDt, bBusy, bDone, bLastSrc;

  int testsRun = 0;
  int testsFailed = 0;

  int   cyc = 0;
  int   xferQ[$];
  int   srcQ[$];
  int   doneQ[$];
  logic bitQ[$];
  int   bothReady = 0;
  logic prevClk = 1'b0;
  int   bXferQ[$];
  int   bDoneQ[$];
  logic bBitQ[$];
  logic bPrevClk = 1'b0;
  logic bClkLog[0:8191];
  logic bDtLog[0:8191];

  always #5 clock = ~clock;

  led_frame_scheduler #(.WIDTH(16), .DIV(2), .GAP(4)) uDut (
    .clock(clock), .reset(reset),
    .io_req0_valid(v0), .io_req0_data(d0), .io_req0_ready(r0),
    .io_req1_valid(v1), .io_req1_data(d1), .io_req1_ready(r1),
    .io_LEDCLK(ledClk), .io_LEDDT(ledDt), .io_busy(busy),
    .io_done(done), .io_last_src(lastSrc)
  );

  led_frame_scheduler #(.WIDTH(16), .DIV(1), .GAP(1)) uFast (
    .clock(clock), .reset(reset),
    .io_req0_valid(bv0), .io_req0_data(bd0), .io_req0_ready(br0),
    .io_req1_valid(bv1), .io_req1_data(bd1), .io_req1_ready(br1),
    .io_LEDCLK(bLedClk), .io_LEDDT(bLedDt), .io_busy(bBusy),
    .io_done(bDone), .io_last_src(bLastSrc)
  );

  // Sample everything at the edge that ends cycle 'cyc'.
  always @(posedge clock) begin
    if (v0 && r0) begin xferQ.push_back(cyc); srcQ.push_back(0); end
    if (v1 && r1) begin xferQ.push_back(cyc); srcQ.push_back(1); end
    if (r0 && r1) bothReady++;
    if (ledClk && !prevClk) bitQ.push_back(ledDt);
    prevClk = ledClk;
    if (done) doneQ.push_back(cyc);
    if ((bv0 && br0) || (bv1 && br1)) bXferQ.push_back(cyc);
    if (bLedClk && !bPrevClk) bBitQ.push_back(bLedDt);
    bPrevClk = bLedClk;
    if (bDone) bDoneQ.push_back(cyc);
    if (cyc < 8192) begin
      bClkLog[cyc] = bLedClk;
      bDtLog[cyc]  = bLedDt;
    end
    cyc++;
  end

  function automatic logic [15:0] frameAt(int s);
    logic [15:0] f;
    f = 'x;
    if (bitQ.size() >= s + 16)
      for (int i = 0; i < 16; i++) f[15-i] = bitQ[s+i];
    return f;
  endfunction

  task automatic clearLogs();
    xferQ.delete(); srcQ.delete(); doneQ.delete(); bitQ.delete();
    bXferQ.delete(); bDoneQ.delete(); bBitQ.delete();
    bothReady = 0;
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin @(posedge clock); #1; end
  endtask

  task automatic doReset();
    reset = 1'b1; v0 = 0; v1 = 0; bv0 = 0; bv1 = 0;
    applyStimulus(2);
    reset = 1'b0;
    clearLogs();
  endtask

  task automatic test_reset();
    reset = 1'b1; v0 = 1'b1; d0 = 16'h1234; v1 = 1'b1; d1 = 16'h4321;
    applyStimulus(2);
    testsRun++; if (r0 !== 1'b0 || r1 !== 1'b0) begin testsFailed++;
      $display("[TB] FAIL reset_ready: got %b%b expected 00", r0, r1); end
    testsRun++; if (busy !== 1'b0) begin testsFailed++;
      $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    testsRun++; if (ledClk !== 1'b0 || ledDt !== 1'b0) begin testsFailed++;
      $display("[TB] FAIL reset_led: got clk=%b dt=%b expected 0/0", ledClk, ledDt); end
    testsRun++; if (done !== 1'b0 || lastSrc !== 1'b0) begin testsFailed++;
      $display("[TB] FAIL reset_done_src: got done=%b src=%b expected 0/0", done, lastSrc); end
    v0 = 0; v1 = 0;
    applyStimulus(1);
    testsRun++; if (xferQ.size() !== 0) begin testsFailed++;
      $display("[TB] FAIL reset_no_xfer: got %0d transfers expected 0", xferQ.size()); end
    reset = 1'b0;
    clearLogs();
  endtask

  task automatic test_req0_alone();
    doReset();
    d0 = 16'hA5C3; v0 = 1'b1;
    for (int i = 0; i < 200 && doneQ.size() == 0; i++) begin
      applyStimulus(1);
      if (xferQ.size() > 0) v0 = 1'b0;
    end
    testsRun++; if (xferQ.size() !== 1 || doneQ.size() !== 1) begin testsFailed++;
      $display("[TB] FAIL req0_counts: got xfer=%0d done=%0d expected 1/1", xferQ.size(), doneQ.size()); end
    testsRun++; if (frameAt(0) !== 16'hA5C3 || bitQ.size() !== 16) begin testsFailed++;
      $display("[TB] FAIL req0_bits: got %h (%0d edges) expected a5c3 (16)", frameAt(0), bitQ.size()); end
    testsRun++;
    if (xferQ.size() < 1 || doneQ.size() < 1 || doneQ[0] - xferQ[0] !== 68) begin testsFailed++;
      $display("[TB] FAIL req0_latency: got %0d expected 68",
               (xferQ.size() > 0 && doneQ.size() > 0) ? doneQ[0] - xferQ[0] : -1); end
    testsRun++; if (lastSrc !== 1'b0 || busy !== 1'b0) begin testsFailed++;
      $display("[TB] FAIL req0_after: got src=%b busy=%b expected 0/0", lastSrc, busy); end
  endtask

  task automatic test_round_robin();
    int badGap;
    logic [3:0] seq;
    doReset();
    d0 = 16'h0001; d1 = 16'h8000; v0 = 1'b1; v1 = 1'b1;
    for (int i = 0; i < 400 && xferQ.size() < 4; i++) applyStimulus(1);
    v0 = 0; v1 = 0;
    for (int i = 0; i < 100 && busy; i++) applyStimulus(1);
    testsRun++; if (xferQ.size() !== 4) begin testsFailed++;
      $display("[TB] FAIL rr_count: got %0d expected 4", xferQ.size()); end
    seq = 4'hx;
    if (srcQ.size() >= 4) seq = {srcQ[0][0], srcQ[1][0], srcQ[2][0], srcQ[3][0]};
    testsRun++; if (seq !== 4'b0101) begin testsFailed++;
      $display("[TB] FAIL rr_order: got %b expected 0101", seq); end
    badGap = 0;
    for (int i = 1; i < xferQ.size(); i++) if (xferQ[i] - xferQ[i-1] != 69) badGap++;
    testsRun++; if (badGap !== 0) begin testsFailed++;
      $display("[TB] FAIL rr_spacing: got %0d gaps not 69 expected 0", badGap); end
    testsRun++; if (bothReady !== 0) begin testsFailed++;
      $display("[TB] FAIL rr_both_ready: got %0d cycles expected 0", bothReady); end
    testsRun++; if (frameAt(0) !== 16'h0001 || frameAt(16) !== 16'h8000) begin testsFailed++;
      $display("[TB] FAIL rr_bits: got %h,%h expected 0001,8000", frameAt(0), frameAt(16)); end
  endtask

  task automatic test_req1_alone();
    doReset();
    d1 = 16'h1234; v1 = 1'b1;
    #1;
    testsRun++; if (r1 !== 1'b1 || r0 !== 1'b0) begin testsFailed++;
      $display("[TB] FAIL req1_immediate: got r0=%b r1=%b expected 0/1", r0, r1); end
    applyStimulus(1);
    d0 = 16'h00FF; v0 = 1'b1;
    for (int i = 0; i < 200 && xferQ.size() < 2; i++) applyStimulus(1);
    v0 = 0; v1 = 0;
    testsRun++;
    if (srcQ.size() < 2 || srcQ[0] !== 1 || srcQ[1] !== 0) begin testsFailed++;
      $display("[TB] FAIL req1_then_rr: got %0d grants first=%0d second=%0d expected 1,0", srcQ.size(),
               srcQ.size() > 0 ? srcQ[0] : -1, srcQ.size() > 1 ? srcQ[1] : -1); end
    testsRun++; if (lastSrc !== 1'b0) begin testsFailed++;
      $display("[TB] FAIL req1_last_src: got %b expected 0", lastSrc); end
    for (int i = 0; i < 100 && busy; i++) applyStimulus(1);
  endtask

  task automatic test_data_change();
    doReset();
    d0 = 16'h0F0F; v0 = 1'b1;
    for (int i = 0; i < 400 && doneQ.size() < 2; i++) begin
      applyStimulus(1);
      if (xferQ.size() == 1) d0 = 16'hF0F0;
      if (xferQ.size() >= 2) v0 = 1'b0;
    end
    v0 = 1'b0;
    testsRun++; if (xferQ.size() !== 2 || doneQ.size() !== 2) begin testsFailed++;
      $display("[TB] FAIL chg_counts: got xfer=%0d done=%0d expected 2/2", xferQ.size(), doneQ.size()); end
    testsRun++; if (frameAt(0) !== 16'h0F0F || frameAt(16) !== 16'hF0F0) begin testsFailed++;
      $display("[TB] FAIL chg_bits: got %h,%h expected 0f0f,f0f0", frameAt(0), frameAt(16)); end
  endtask

  task automatic test_mid_reset();
    doReset();
    d0 = 16'hFFFF; v0 = 1'b1;
    for (int i = 0; i < 10 && xferQ.size() == 0; i++) applyStimulus(1);
    v0 = 1'b0;
    applyStimulus(19);
    testsRun++; if (ledClk !== 1'b1 || busy !== 1'b1) begin testsFailed++;
      $display("[TB] FAIL midrst_before: got clk=%b busy=%b expected 1/1", ledClk, busy); end
    reset = 1'b1;
    applyStimulus(1);
    testsRun++; if (ledClk !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin testsFailed++;
      $display("[TB] FAIL midrst_abort: got clk=%b busy=%b done=%b expected 0/0/0", ledClk, busy, done); end
    reset = 1'b0;
    applyStimulus(80);
    testsRun++; if (doneQ.size() !== 0) begin testsFailed++;
      $display("[TB] FAIL midrst_no_done: got %0d done pulses expected 0", doneQ.size()); end
    clearLogs();
    d0 = 16'h8001; d1 = 16'h7FFE; v0 = 1'b1; v1 = 1'b1;
    for (int i = 0; i < 200 && doneQ.size() == 0; i++) begin
      applyStimulus(1);
      if (xferQ.size() > 0) begin v0 = 1'b0; v1 = 1'b0; end
    end
    testsRun++; if (srcQ.size() !== 1 || srcQ[0] !== 0) begin testsFailed++;
      $display("[TB] FAIL midrst_ptr: got %0d grants src=%0d expected 1 grant src=0", srcQ.size(),
               srcQ.size() > 0 ? srcQ[0] : -1); end
    testsRun++; if (frameAt(0) !== 16'h8001 || bitQ.size() !== 16) begin testsFailed++;
      $display("[TB] FAIL midrst_restart: got %h (%0d edges) expected 8001 (16)", frameAt(0), bitQ.size()); end
  endtask

  task automatic test_div1();
    int badClk, badDt;
    logic [15:0] f;
    doReset();
    bd0 = 16'hFFFF; bv0 = 1'b1;
    for (int i = 0; i < 100 && bDoneQ.size() == 0; i++) begin
      applyStimulus(1);
      if (bXferQ.size() > 0) bv0 = 1'b0;
    end
    bv0 = 1'b0;
    f = 'x;
    if (bBitQ.size() == 16) for (int i = 0; i < 16; i++) f[15-i] = bBitQ[i];
    testsRun++; if (f !== 16'hFFFF) begin testsFailed++;
      $display("[TB] FAIL div1_bits: got %h (%0d edges) expected ffff (16)", f, bBitQ.size()); end
    testsRun++;
    if (bXferQ.size() < 1 || bDoneQ.size() < 1 || bDoneQ[0] - bXferQ[0] !== 33) begin testsFailed++;
      $display("[TB] FAIL div1_latency: got %0d expected 33",
               (bXferQ.size() > 0 && bDoneQ.size() > 0) ? bDoneQ[0] - bXferQ[0] : -1); end
    badClk = 0; badDt = 0;
    if (bXferQ.size() > 0) begin
      for (int k = 1; k <= 33; k++) begin
        if (bClkLog[bXferQ[0]+k] !== ((k % 2 == 0) ? 1'b1 : 1'b0)) badClk++;
        if (k <= 32 && bDtLog[bXferQ[0]+k] !== 1'b1) badDt++;
      end
    end else begin
      badClk = -1; badDt = -1;
    end
    testsRun++; if (badClk !== 0) begin testsFailed++;
      $display("[TB] FAIL div1_toggle: got %0d bad clock cycles expected 0", badClk); end
    testsRun++; if (badDt !== 0) begin testsFailed++;
      $display("[TB] FAIL div1_data: got %0d cycles with LEDDT!=1 expected 0", badDt); end
  endtask

  initial begin
    #1;
    test_reset();
    test_req0_alone();
    test_round_robin();
    test_req1_alone();
    test_data_change();
    test_mid_reset();
    test_div1();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/led_frame_scheduler.md
Name: led_frame_scheduler

Overview:
- Sequences the serial LED shift-register chain driven by LEDCLK/LEDDT on the 200 MHz domain.
- Arbitrates between two pattern requesters with a round-robin valid/ready handshake.
- Latches the winning WIDTH-bit pattern and shifts it out MSB first, with a divided serial clock and an inter-frame gap.
- Sits between the top level and any LED pattern producers, replacing direct ownership of the LED pins.

Parameters:
WIDTH, 16, bits per frame (LED chain length); must be >= 2
DIV, 8, clock cycles per serial-clock half period; must be >= 1
GAP, 16, idle cycles after the final bit before the next grant; must be >= 1

Ports:
clock  input  1  system clock, 200 MHz
reset  input  1  synchronous, active-high reset
io_req0_valid  input  1  requester 0 has a pattern
io_req0_data  input  WIDTH  requester 0 pattern; bit WIDTH-1 is shifted first
io_req0_ready  output  1  requester 0 pattern accepted this cycle
io_req1_valid  input  1  requester 1 has a pattern
io_req1_data  input  WIDTH  requester 1 pattern
io_req1_ready  output  1  requester 1 pattern accepted this cycle
io_LEDCLK  output  1  serial clock to the LED chain; chain samples on the rising edge
io_LEDDT  output  1  serial data to the LED chain
io_busy  output  1  frame in progress (any state other than IDLE)
io_done  output  1  one-cycle pulse on the last GAP cycle
io_last_src  output  1  index of the requester whose frame was most recently accepted

Behaviour:
- Clock and reset: single clock domain `clock`. Reset is synchronous and active-high on `reset`.
- Reset values: state=IDLE, io_LEDCLK=0, io_LEDDT=0, io_busy=0, io_done=0, io_last_src=0, rr pointer=0, shift register=0, counters=0.
- States: IDLE, SHIFT_LO, SHIFT_HI, GAP.
- ready is combinational:
  - io_reqK_ready = (state==IDLE) && !reset && grant==K.
  - At most one ready is high per cycle.
- Grant rule in IDLE:
  - Only one valid: that requester is granted.
  - Both valid: requester == rr pointer is granted.
  - Neither valid: no grant.
- Transfer occurs when valid && ready in the same cycle. On transfer:
  - Latch data into the shift register.
  - io_last_src <= K.
  - rr pointer <= ~K.
  - Bit counter <= WIDTH-1, divider <= 0.
  - Next state = SHIFT_LO.
- SHIFT_LO: io_LEDCLK=0, io_LEDDT = shift register MSB, held DIV cycles, then go to SHIFT_HI.
- SHIFT_HI: io_LEDCLK=1, io_LEDDT unchanged, held DIV cycles. Then:
  - bit counter != 0: shift left by 1, decrement the counter, go to SHIFT_LO.
  - bit counter == 0: go to GAP.
- GAP: io_LEDCLK=0, io_LEDDT=0, held GAP cycles. io_done=1 on the final GAP cycle only, then go to IDLE.
- Output registers: io_LEDCLK and io_LEDDT are registered. The first SHIFT_LO cycle presents bit WIDTH-1 in the cycle after the transfer.
- Frame latency: transfer cycle to io_done = 2*DIV*WIDTH + GAP cycles. The earliest next transfer is the cycle after io_done.
- Data stability: io_LEDDT changes only while io_LEDCLK=0. It is stable for DIV cycles before each rising edge and for DIV cycles after it.
- Requests during a frame: valid asserted while busy is held off (ready=0). Requesters must hold valid and data until ready. Data changes while busy have no effect.
- Requester 1 alone is granted immediately even when the pointer favours requester 0; the pointer then becomes 0.
- Reset mid-frame: aborts the frame on the next edge. io_LEDCLK falls to 0 and no partial-frame io_done is produced. The pointer returns to 0.
- Reset and valid in the same cycle: no ready, no transfer.

Test Plan (DIV=2, WIDTH=16, GAP=4; frame = 68 cycles):
- Req0 alone, data=16'hA5C3 -> ready0 pulses once; io_LEDDT sampled at the 16 io_LEDCLK rising edges reads 1010_0101_1100_0011; io_done 68 cycles after transfer; io_last_src=0.
- Both valid continuously after reset, req0=16'h0001, req1=16'h8000 -> grants alternate 0,1,0,1; transfers are exactly 69 cycles apart; no cycle has both ready high.
- Req1 alone after reset -> immediate grant to 1; then both valid -> next grant goes to 0.
- Req0 changes data mid-frame with valid held -> the first frame still shifts the originally latched value; the new value goes in the next frame.
- Reset asserted 20 cycles into a frame -> next cycle io_LEDCLK=0, io_busy=0, no io_done; a fresh request restarts cleanly from bit 15.
- DIV=1, GAP=1 build, data=16'hFFFF -> io_LEDCLK toggles every cycle, 16 rising edges, io_LEDDT=1 throughout the shift, frame = 33 cycles.
